// File: rtl/dp_pkg.sv
// ---------------------------------------------------------------------------
// dp_pkg : shared widths and operand/result types for the datapath driver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dp_pkg;
  localparam int DW        = 64;
  localparam int RW        = 32;
  localparam int DEPTH_DEF = 4;
  localparam int LAT_DEF   = 2;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } operand_t;

  typedef struct packed {
    logic [RW-1:0] x;
    logic [RW-1:0] z;
  } result_t;
endpackage

`default_nettype wire

// File: rtl/dp_issue_collect_if.sv
// ---------------------------------------------------------------------------
// dp_issue_collect_if : operand input, datapath and result drain signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dp_issue_collect_if;
  import dp_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] in_c;
  logic [DW-1:0] dp_a;
  logic [DW-1:0] dp_b;
  logic [DW-1:0] dp_c;
  logic [RW-1:0] dp_x;
  logic [RW-1:0] dp_z;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_x;
  logic [RW-1:0] out_z;
  logic          busy;

  modport slave (
    input  in_valid, in_a, in_b, in_c, dp_x, dp_z, out_ready,
    output in_ready, dp_a, dp_b, dp_c, out_valid, out_x, out_z, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_c, dp_x, dp_z, out_ready,
    input  in_ready, dp_a, dp_b, dp_c, out_valid, out_x, out_z, busy
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO, synchronous active-low reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire logic [W-1:0]             i_data,
  input  wire logic                     i_pop,
  output logic      [W-1:0]             o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/dp_issue_collect.sv
// ---------------------------------------------------------------------------
// dp_issue_collect : buffers operand triples, issues them to the datapath and
//                    collects the matching results in order.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dp_issue_collect
  import dp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  wire logic               clk,
  input  wire logic               rst,
  dp_issue_collect_if.slave       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 2) + 1;

  operand_t       w_op_in;
  operand_t       w_op_head;
  result_t        w_res_in;
  result_t        w_res_head;
  logic           w_op_full;
  logic           w_op_empty;
  logic [AW:0]    w_op_count;
  logic           w_res_full;
  logic           w_res_empty;
  logic [AW:0]    w_res_count;
  logic           w_push;
  logic           w_issue;
  logic           w_res_push;
  logic           w_res_pop;
  logic [CW-1:0]  w_committed;
  logic           w_unused;

  operand_t       r_dp;
  logic           r_iss;
  logic [LAT-1:0] r_tag;

  assign w_op_in     = '{a: bus.in_a, b: bus.in_b, c: bus.in_c};
  assign w_res_in    = '{x: bus.dp_x, z: bus.dp_z};
  assign bus.in_ready = rst && !w_op_full;
  assign w_push      = bus.in_valid && bus.in_ready;
  assign w_res_pop   = bus.out_ready && !w_res_empty;
  assign w_res_push  = r_tag[LAT-1];
  assign w_unused    = w_res_full;

  // Every issued triple owns a result slot from issue until it is drained.
  always_comb begin
    w_committed = CW'(r_iss) + CW'(w_res_count);
    for (int i = 0; i < LAT; i++) begin
      w_committed = w_committed + CW'(r_tag[i]);
    end
  end

  assign w_issue = !w_op_empty && (w_committed < (CW'(DEPTH) + CW'(w_res_pop)));

  // r_iss marks dp_a/b/c holding a fresh triple; r_tag then follows it through
  // the LAT datapath registers so capture lines up with its dp_x/dp_z.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dp  <= '0;
      r_iss <= 1'b0;
      r_tag <= '0;
    end else begin
      r_iss <= w_issue;
      r_tag <= (r_tag << 1) | LAT'(r_iss);
      if (w_issue) begin
        r_dp <= w_op_head;
      end
    end
  end

  sync_fifo #(.W($bits(operand_t)), .DEPTH(DEPTH)) u_op_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_op_in),
    .i_pop   (w_issue),
    .o_data  (w_op_head),
    .o_full  (w_op_full),
    .o_empty (w_op_empty),
    .o_count (w_op_count)
  );

  sync_fifo #(.W($bits(result_t)), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_res_push),
    .i_data  (w_res_in),
    .i_pop   (w_res_pop),
    .o_data  (w_res_head),
    .o_full  (w_res_full),
    .o_empty (w_res_empty),
    .o_count (w_res_count)
  );

  assign bus.dp_a      = r_dp.a;
  assign bus.dp_b      = r_dp.b;
  assign bus.dp_c      = r_dp.c;
  assign bus.out_valid = !w_res_empty;
  assign bus.out_x     = w_res_head.x;
  assign bus.out_z     = w_res_head.z;
  assign bus.busy      = (w_op_count != '0) || r_iss || (|r_tag) || !w_res_empty;
endmodule

`default_nettype wire

// File: tb/tb_dp_issue_collect.sv
// ---------------------------------------------------------------------------
// tb_dp_issue_collect : directed bench with a stub datapath and a scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dp_issue_collect;
  import dp_pkg::*;

  localparam int TB_DEPTH = 4;
  localparam int TB_LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] exp_q [$];

  dp_issue_collect_if bus ();

  dp_issue_collect #(.DEPTH(TB_DEPTH), .LAT(TB_LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // standalone result-style FIFO for the full push+pop corner
  logic       f_push = 1'b0;
  logic       f_pop  = 1'b0;
  logic [7:0] f_data = '0;
  logic [7:0] f_q;
  logic       f_full;
  logic       f_empty;
  logic [2:0] f_cnt;

  sync_fifo #(.W(8), .DEPTH(4)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (f_push),
    .i_data  (f_data),
    .i_pop   (f_pop),
    .o_data  (f_q),
    .o_full  (f_full),
    .o_empty (f_empty),
    .o_count (f_cnt)
  );

  always #5 clk = ~clk;

  // stub datapath: x = a[31:0], z = b[31:0], TB_LAT registers deep
  logic [RW-1:0] r_sx [TB_LAT];
  logic [RW-1:0] r_sz [TB_LAT];
  always @(posedge clk) begin
    r_sx[0] <= bus.dp_a[RW-1:0];
    r_sz[0] <= bus.dp_b[RW-1:0];
    for (int i = 1; i < TB_LAT; i++) begin
      r_sx[i] <= r_sx[i-1];
      r_sz[i] <= r_sz[i-1];
    end
  end
  assign bus.dp_x = r_sx[TB_LAT-1];
  assign bus.dp_z = r_sz[TB_LAT-1];

  // scoreboard: handshakes sampled at negedge are exactly those the next posedge takes
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%h expected=none", {bus.out_x, bus.out_z});
      end else begin
        e = exp_q.pop_front();
        assert ({bus.out_x, bus.out_z} === e) else begin
          n_fail++;
          $error("FAIL sb_result observed=%h expected=%h", {bus.out_x, bus.out_z}, e);
        end
      end
    end
    if (rst && bus.in_valid && bus.in_ready) begin
      exp_q.push_back({bus.in_a[RW-1:0], bus.in_b[RW-1:0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_accept", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int first, nval, gap, stalls, stale;
    logic [7:0] f_exp [4];

    bus.in_valid  = 1'b1;
    bus.in_a      = 64'hDEAD;
    bus.in_b      = 64'hBEEF;
    bus.in_c      = '0;
    bus.out_ready = 1'b0;

    // 1. reset with in_valid held high
    repeat (3) tick();
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_dp_a",      bus.dp_a,           64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_out_x",     64'(bus.out_x),     64'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 2. single operation: dp_a one cycle after accept, out_valid at LAT+2
    send(64'd5, 64'd3, 64'd1);
    for (int k = 1; k <= TB_LAT + 2; k++) begin
      tick();
      if (k == 1) check("single_dp_a", bus.dp_a, 64'd5);
      if (k < TB_LAT + 2) check("single_early_valid", 64'(bus.out_valid), 64'd0);
      else                check("single_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_busy", 64'(bus.busy), 64'd0);
    check("single_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3. back-pressure: 8 triples fill issue credits and the operand FIFO
    for (int i = 1; i <= 8; i++) send(64'(i), 64'(i + 100), 64'(i + 200));
    repeat (TB_LAT + 3) tick();
    check("bp_in_ready", 64'(bus.in_ready),  64'd0);
    check("bp_valid",    64'(bus.out_valid), 64'd1);
    check("bp_head",     64'(bus.out_x),     64'd1);
    check("bp_busy",     64'(bus.busy),      64'd1);
    bus.out_ready = 1'b1;
    drain("bp_drain");
    check("bp_busy_end", 64'(bus.busy), 64'd0);

    // 4. streaming 100 triples with out_ready held
    first = -1; nval = 0; gap = 0; stalls = 0;
    for (int j = 0; j < 110; j++) begin
      if (j < 100) begin
        bus.in_valid = 1'b1;
        bus.in_a = 64'(j);
        bus.in_b = 64'(j * 7 + 1);
        bus.in_c = 64'(j);
        if (!bus.in_ready) stalls++;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (bus.out_valid) begin
        if (first < 0) first = j;
        nval++;
      end else if (first >= 0 && nval < 100) begin
        gap++;
      end
    end
    check("stream_stalls",  64'(stalls), 64'd0);
    check("stream_latency", 64'(first),  64'(TB_LAT + 2));
    check("stream_count",   64'(nval),   64'd100);
    check("stream_bubbles", 64'(gap),    64'd0);
    check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

    // 5. full FIFO with push and pop on the same edge
    for (int k = 0; k < 4; k++) begin
      f_push = 1'b1;
      f_data = 8'hA0 + 8'(k);
      tick();
    end
    check("full_flag",  64'(f_full), 64'd1);
    check("full_count", 64'(f_cnt),  64'd4);
    check("full_head",  64'(f_q),    64'hA0);
    f_pop  = 1'b1;
    f_data = 8'hB0;
    tick();
    f_push = 1'b0;
    check("simul_count", 64'(f_cnt),  64'd4);
    check("simul_full",  64'(f_full), 64'd1);
    check("simul_head",  64'(f_q),    64'hA1);
    f_exp = '{8'hA2, 8'hA3, 8'hB0, 8'h00};
    for (int k = 0; k < 3; k++) begin
      tick();
      check("simul_order", 64'(f_q), 64'(f_exp[k]));
    end
    tick();
    f_pop = 1'b0;
    check("simul_empty", 64'(f_empty), 64'd1);

    // 6. reset with triples in flight
    bus.out_ready = 1'b0;
    send(64'h11, 64'h21, 64'h0);
    send(64'h12, 64'h22, 64'h0);
    send(64'h13, 64'h23, 64'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid",    64'(bus.out_valid), 64'd0);
    check("mid_rst_busy",     64'(bus.busy),      64'd0);
    check("mid_rst_dp_a",     bus.dp_a,           64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.out_valid || bus.busy) stale++;
    end
    check("mid_rst_stale", 64'(stale), 64'd0);

    send(64'h77, 64'h88, 64'h99);
    drain("post_rst_drain");
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
